// File: rtl/target_weight_loader.sv
// Copies a full main-network weight set (hidden-1, hidden-2, output) from the source
// weight RAM into the target network's weight-load stream, one word per cycle.
module target_weight_loader #(
    parameter int DATA_WIDTH                    = 32,
    parameter int LAYER_WIDTH                   = 2,
    parameter int NUMBER_OF_INPUT_NODE          = 2,
    parameter int NUMBER_OF_HIDDEN_NODE_LAYER_1 = 32,
    parameter int NUMBER_OF_HIDDEN_NODE_LAYER_2 = 32,
    parameter int NUMBER_OF_OUTPUT_NODE         = 3,
    parameter int WEIGHT_COUNTER_WIDTH          = 11
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_start,
    output logic                            o_busy,
    output logic                            o_done,
    output logic                            o_ram_rd_en,
    output logic [LAYER_WIDTH-1:0]          o_ram_rd_layer,
    output logic [WEIGHT_COUNTER_WIDTH-1:0] o_ram_rd_addr,
    input  logic [DATA_WIDTH-1:0]           i_ram_rd_data,
    output logic                            o_weight_valid,
    output logic [LAYER_WIDTH-1:0]          o_weight_layer,
    output logic [WEIGHT_COUNTER_WIDTH-1:0] o_weight_addr,
    output logic [DATA_WIDTH-1:0]           o_weight
);

    // state   | meaning
    // IDLE    | waiting for i_start
    // RD_L1   | reading hidden-1 weights, one address per cycle
    // GAP1    | single idle cycle between layers
    // RD_L2   | reading hidden-2 weights
    // GAP2    | single idle cycle between layers
    // RD_OUT  | reading output-layer weights
    // FLUSH   | last read data is being forwarded
    typedef enum logic [2:0] {
        S_IDLE, S_RD_L1, S_GAP1, S_RD_L2, S_GAP2, S_RD_OUT, S_FLUSH
    } state_t;

    localparam int N1 = NUMBER_OF_HIDDEN_NODE_LAYER_1 * (NUMBER_OF_INPUT_NODE + 1);
    localparam int N2 = NUMBER_OF_HIDDEN_NODE_LAYER_2 * (NUMBER_OF_HIDDEN_NODE_LAYER_1 + 1);
    localparam int N3 = NUMBER_OF_OUTPUT_NODE * (NUMBER_OF_HIDDEN_NODE_LAYER_2 + 1);

    localparam logic [WEIGHT_COUNTER_WIDTH-1:0] LAST1 = WEIGHT_COUNTER_WIDTH'(N1 - 1);
    localparam logic [WEIGHT_COUNTER_WIDTH-1:0] LAST2 = WEIGHT_COUNTER_WIDTH'(N2 - 1);
    localparam logic [WEIGHT_COUNTER_WIDTH-1:0] LAST3 = WEIGHT_COUNTER_WIDTH'(N3 - 1);

    localparam logic [LAYER_WIDTH-1:0] LAYER_H1  = LAYER_WIDTH'(1);
    localparam logic [LAYER_WIDTH-1:0] LAYER_H2  = LAYER_WIDTH'(2);
    localparam logic [LAYER_WIDTH-1:0] LAYER_OUT = LAYER_WIDTH'(3);

    state_t                            state_q, state_d, rd_next;
    logic [WEIGHT_COUNTER_WIDTH-1:0]   addr_q, addr_d, last_addr;
    logic                              rd_en;
    logic [LAYER_WIDTH-1:0]            rd_layer;
    logic [WEIGHT_COUNTER_WIDTH-1:0]   rd_addr;

    logic                              wv_q;
    logic [LAYER_WIDTH-1:0]            wl_q;
    logic [WEIGHT_COUNTER_WIDTH-1:0]   wa_q;
    logic                              done_q;
    logic [DATA_WIDTH-1:0]             held_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rd_next   = S_IDLE;
        rd_en     = 1'b0;
        rd_layer  = '0;
        last_addr = '0;
        case (state_q)
            S_IDLE:   if (i_start) state_d = S_RD_L1;
            S_RD_L1:  begin rd_en = 1'b1; rd_layer = LAYER_H1;  last_addr = LAST1; rd_next = S_GAP1;  end
            S_GAP1:   state_d = S_RD_L2;
            S_RD_L2:  begin rd_en = 1'b1; rd_layer = LAYER_H2;  last_addr = LAST2; rd_next = S_GAP2;  end
            S_GAP2:   state_d = S_RD_OUT;
            S_RD_OUT: begin rd_en = 1'b1; rd_layer = LAYER_OUT; last_addr = LAST3; rd_next = S_FLUSH; end
            S_FLUSH:  state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        // Address counter restarts at 0 for every layer; terminal count ends the layer.
        if (rd_en) begin
            if (addr_q == last_addr) begin
                addr_d  = '0;
                state_d = rd_next;
            end else begin
                addr_d = addr_q + WEIGHT_COUNTER_WIDTH'(1);
            end
        end
    end

    assign rd_addr = rd_en ? addr_q : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            wv_q   <= 1'b0;
            wl_q   <= '0;
            wa_q   <= '0;
            done_q <= 1'b0;
            held_q <= '0;
        end else begin
            wv_q   <= rd_en;
            wl_q   <= rd_layer;
            wa_q   <= rd_addr;
            done_q <= (state_q == S_FLUSH);
            if (wv_q) held_q <= i_ram_rd_data;
        end
    end

    assign o_busy         = (state_q != S_IDLE);
    assign o_done         = done_q;
    assign o_ram_rd_en    = rd_en;
    assign o_ram_rd_layer = rd_layer;
    assign o_ram_rd_addr  = rd_addr;
    assign o_weight_valid = wv_q;
    assign o_weight_layer = wl_q;
    assign o_weight_addr  = wa_q;
    // RAM data arrives in the same cycle as the delayed valid; outside valid the last word is kept.
    assign o_weight       = wv_q ? i_ram_rd_data : held_q;

endmodule
